// File: rtl/regfile_sb.sv
// regfile_sb: parametrised multi-read-port register file with a pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN enables same-cycle writeback-to-read forwarding.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                       Clk,
    input  logic                       rst,
    input  logic                       WEN,
    input  logic [ADDR_W-1:0]          RW,
    input  logic [DATA_W-1:0]          busW,
    input  logic [NUM_RD*ADDR_W-1:0]   RD_ADDR,
    output logic [NUM_RD*DATA_W-1:0]   RD_DATA,
    output logic [NUM_RD-1:0]          RD_BUSY,
    input  logic                       ISS,
    input  logic [ADDR_W-1:0]          ISS_RW,
    input  logic                       FLUSH,
    output logic [ADDR_W:0]            PEND_CNT
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic [DEPTH-1:0]  w_pend_nxt;
    logic [ADDR_W:0]   r_pend_cnt;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic              w_wb_v;
    logic              w_iss_v;
    logic              w_inc;
    logic              w_dec;

    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{ADDR_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    assign w_wb_v  = WEN && (RW != '0);
    assign w_iss_v = ISS && (ISS_RW != '0);

    // Later assignments win: a new issue overrides both flush and writeback clear.
    always_comb begin
        w_pend_nxt = FLUSH ? '0 : r_pend;
        if (w_wb_v) begin
            w_pend_nxt[RW] = 1'b0;
        end
        if (w_iss_v) begin
            w_pend_nxt[ISS_RW] = 1'b1;
        end
    end

    assign w_inc = w_iss_v && !r_pend[ISS_RW];
    assign w_dec = w_wb_v && r_pend[RW] && !(w_iss_v && (ISS_RW == RW));

    always_comb begin
        if (FLUSH) begin
            w_cnt_nxt = popcount(w_pend_nxt);
        end else begin
            w_cnt_nxt = r_pend_cnt + {{ADDR_W{1'b0}}, w_inc} - {{ADDR_W{1'b0}}, w_dec};
        end
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            r_pend     <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_pend     <= w_pend_nxt;
            r_pend_cnt <= w_cnt_nxt;
        end
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_v) begin
            r_regs[RW] <= busW;
        end
    end

    assign PEND_CNT = r_pend_cnt;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic              w_hit;

        assign w_ra = RD_ADDR[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        assign w_hit = w_wb_v && (w_ra == RW);
`else
        assign w_hit = 1'b0;
`endif
        assign RD_DATA[k*DATA_W +: DATA_W] = (w_ra == '0) ? '0 :
                                             w_hit        ? busW :
                                                            r_regs[w_ra];
        // A forwarded writeback retires the hazard unless a new producer issues to it now.
        assign RD_BUSY[k] = (w_ra == '0) ? 1'b0 :
                            w_hit        ? (w_iss_v && (ISS_RW == w_ra)) :
                                           r_pend[w_ra];
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed testbench for regfile_sb: default 32x32 2-port instance plus a 64-bit/16-deep/3-port instance.
module tb_regfile_sb;
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        rst;
    logic        WEN, ISS, FLUSH;
    logic [4:0]  RW, ISS_RW;
    logic [31:0] busW;
    logic [9:0]  RD_ADDR;
    logic [63:0] RD_DATA;
    logic [1:0]  RD_BUSY;
    logic [5:0]  PEND_CNT;

    logic         wen2, iss2, flush2;
    logic [3:0]   rw2, iss_rw2;
    logic [63:0]  busw2;
    logic [11:0]  raddr2;
    logic [191:0] rdata2;
    logic [2:0]   busy2;
    logic [4:0]   cnt2;

    regfile_sb u_dut (
        .Clk(Clk), .rst(rst), .WEN(WEN), .RW(RW), .busW(busW),
        .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .RD_BUSY(RD_BUSY),
        .ISS(ISS), .ISS_RW(ISS_RW), .FLUSH(FLUSH), .PEND_CNT(PEND_CNT)
    );

    regfile_sb #(.DATA_W(64), .ADDR_W(4), .NUM_RD(3)) u_dut2 (
        .Clk(Clk), .rst(rst), .WEN(wen2), .RW(rw2), .busW(busw2),
        .RD_ADDR(raddr2), .RD_DATA(rdata2), .RD_BUSY(busy2),
        .ISS(iss2), .ISS_RW(iss_rw2), .FLUSH(flush2), .PEND_CNT(cnt2)
    );

    typedef struct {
        logic        wen;
        logic [4:0]  rw;
        logic [31:0] busw;
        logic        iss;
        logic [4:0]  iss_rw;
        logic        flush;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
        logic [1:0]  e_busy;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vecs [15];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic bypass;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pat2(input int i);
        if (i == 0) return 64'd0;
        return {16'hBEEF, 16'(i), 32'(i) * 32'h01010101};
    endfunction

    task automatic idle1();
        WEN = 1'b0; ISS = 1'b0; FLUSH = 1'b0;
        RW = '0; ISS_RW = '0; busW = '0;
    endtask

    initial begin
`ifdef REGFILE_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        //          wen   rw     busw          iss   iss_rw flush ra0    ra1    e_d0          e_d1          busy   cnt
        vecs[0]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 6'd0};
        vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        2'b00, 6'd0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd3,  5'd7,  32'h0,        32'h0,        2'b01, 6'd1};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b0, 5'd3,  5'd7,  32'h0,        32'h0,        2'b11, 6'd2};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd3,  5'd7,  32'h0,        32'h0,        2'b11, 6'd2};
        vecs[5]  = '{1'b1, 5'd3,  32'h12345678, 1'b0, 5'd0,  1'b0, 5'd3,  5'd7,  32'h12345678, 32'h0,        2'b10, 6'd1};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd9,  5'd7,  32'h0,        32'h0,        2'b11, 6'd2};
        vecs[7]  = '{1'b1, 5'd9,  32'hAAAA0009, 1'b1, 5'd9,  1'b0, 5'd9,  5'd7,  32'hAAAA0009, 32'h0,        2'b11, 6'd2};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  1'b0, 5'd1,  5'd9,  32'h0,        32'hAAAA0009, 2'b11, 6'd3};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd2,  1'b0, 5'd2,  5'd7,  32'h0,        32'h0,        2'b11, 6'd4};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  1'b1, 5'd4,  5'd9,  32'h0,        32'hAAAA0009, 2'b01, 6'd1};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd4,  5'd0,  32'h0,        32'h0,        2'b00, 6'd0};
        vecs[12] = '{1'b1, 5'd20, 32'h00001234, 1'b0, 5'd0,  1'b0, 5'd20, 5'd4,  32'h00001234, 32'h0,        2'b00, 6'd0};
        vecs[13] = '{1'b1, 5'd5,  32'h00000005, 1'b1, 5'd31, 1'b0, 5'd31, 5'd5,  32'h0,        32'h00000005, 2'b01, 6'd1};
        vecs[14] = '{1'b1, 5'd31, 32'h00000031, 1'b1, 5'd6,  1'b0, 5'd31, 5'd6,  32'h00000031, 32'h0,        2'b10, 6'd1};

        idle1();
        RD_ADDR = '0;
        wen2 = 1'b0; iss2 = 1'b0; flush2 = 1'b0;
        rw2 = '0; iss_rw2 = '0; busw2 = '0; raddr2 = '0;

        // Reset held while inputs toggle randomly
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            WEN     = bypass ? 1'b0 : 1'($urandom_range(0, 1));
            RW      = 5'($urandom_range(0, 31));
            busW    = $urandom;
            ISS     = 1'($urandom_range(0, 1));
            ISS_RW  = 5'($urandom_range(0, 31));
            FLUSH   = 1'($urandom_range(0, 1));
            RD_ADDR = 10'($urandom_range(0, 1023));
            @(posedge Clk);
            #1;
            check("reset_rd_data", {32'd0, RD_DATA}, {32'd0, 64'd0} );
            check("reset_busy_cnt", {56'd0, RD_BUSY, PEND_CNT}, 64'd0);
        end
        @(negedge Clk);
        idle1();
        RD_ADDR = '0;
        rst = 1'b0;

        // Write r5, then reset asynchronously mid-cycle
        @(negedge Clk);
        WEN = 1'b1; RW = 5'd5; busW = 32'hDEADBEEF;
        @(posedge Clk);
        #1;
        idle1();
        RD_ADDR = {5'd0, 5'd5};
        #1;
        check("r5_before_async_rst", {32'd0, RD_DATA[31:0]}, 64'hDEADBEEF);
        #1;
        rst = 1'b1;
        #1;
        check("r5_after_async_rst", {32'd0, RD_DATA[31:0]}, 64'd0);
        @(negedge Clk);
        rst = 1'b0;

        // Table-driven vectors: outputs checked after the edge with strobes removed
        for (int v = 0; v < 15; v++) begin
            @(negedge Clk);
            WEN = vecs[v].wen; RW = vecs[v].rw; busW = vecs[v].busw;
            ISS = vecs[v].iss; ISS_RW = vecs[v].iss_rw; FLUSH = vecs[v].flush;
            RD_ADDR = {vecs[v].ra1, vecs[v].ra0};
            @(posedge Clk);
            #1;
            idle1();
            #1;
            check($sformatf("vec%0d_rd0", v), {32'd0, RD_DATA[31:0]}, {32'd0, vecs[v].e_d0});
            check($sformatf("vec%0d_rd1", v), {32'd0, RD_DATA[63:32]}, {32'd0, vecs[v].e_d1});
            check($sformatf("vec%0d_busy", v), {62'd0, RD_BUSY}, {62'd0, vecs[v].e_busy});
            check($sformatf("vec%0d_cnt", v), {58'd0, PEND_CNT}, {58'd0, vecs[v].e_cnt});
        end

        // Same-cycle writeback visibility on r12 (pending r6 left from the table)
        @(negedge Clk);
        WEN = 1'b1; RW = 5'd12; busW = 32'h00000011; ISS = 1'b1; ISS_RW = 5'd12;
        @(posedge Clk);
        #1;
        idle1();
        @(negedge Clk);
        RD_ADDR = {5'd12, 5'd6};
        WEN = 1'b1; RW = 5'd12; busW = 32'hCAFE0001;
        #1;
        check("bypass_same_cycle_data", {32'd0, RD_DATA[63:32]}, bypass ? 64'hCAFE0001 : 64'h11);
        check("bypass_same_cycle_busy", {63'd0, RD_BUSY[1]}, bypass ? 64'd0 : 64'd1);
        check("bypass_same_cycle_cnt", {58'd0, PEND_CNT}, 64'd2);
        @(posedge Clk);
        #1;
        idle1();
        #1;
        check("bypass_next_cycle_data", {32'd0, RD_DATA[63:32]}, 64'hCAFE0001);
        check("bypass_next_cycle_busy", {62'd0, RD_BUSY}, 64'b01);
        check("bypass_next_cycle_cnt", {58'd0, PEND_CNT}, 64'd1);

        // Wide instance: fill, read three ports, then issue everything
        for (int i = 1; i < 16; i++) begin
            @(negedge Clk);
            wen2 = 1'b1; rw2 = 4'(i); busw2 = pat2(i);
            @(posedge Clk);
            #1;
            wen2 = 1'b0;
        end
        for (int i = 1; i < 16; i++) begin
            int a, b, c;
            a = i; b = (i + 4) % 16; c = (i + 9) % 16;
            raddr2 = {4'(c), 4'(b), 4'(a)};
            #2;
            check($sformatf("w64_p0_r%0d", a), rdata2[63:0],    pat2(a));
            check($sformatf("w64_p1_r%0d", b), rdata2[127:64],  pat2(b));
            check($sformatf("w64_p2_r%0d", c), rdata2[191:128], pat2(c));
        end
        for (int i = 1; i < 16; i++) begin
            @(negedge Clk);
            iss2 = 1'b1; iss_rw2 = 4'(i);
            @(posedge Clk);
            #1;
            iss2 = 1'b0;
        end
        raddr2 = {4'd15, 4'd1, 4'd0};
        #2;
        check("w64_cnt_all_issued", {59'd0, cnt2}, 64'd15);
        check("w64_busy_all_issued", {61'd0, busy2}, 64'b110);
        @(negedge Clk);
        flush2 = 1'b1;
        @(posedge Clk);
        #1;
        flush2 = 1'b0;
        #1;
        check("w64_cnt_after_flush", {59'd0, cnt2}, 64'd0);
        check("w64_busy_after_flush", {61'd0, busy2}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port register file with a per-register pending-write scoreboard for the pipelined CPU core. It generalises the 32x32 two-read/one-write register file in data width, address width and read-port count. It tracks registers with an issued-but-not-written-back result, so the hazard unit can stall on `RD_BUSY`. Register 0 reads as zero and is never written.

## Interface
Parameters:
- `DATA_W`, 32: register width in bits.
- `ADDR_W`, 5: register address width; depth is `2**ADDR_W`.
- `NUM_RD`, 2: number of read ports, at least 1.

Ports:
- `Clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `WEN`  in  1  writeback enable.
- `RW`  in  `ADDR_W`  writeback register address.
- `busW`  in  `DATA_W`  writeback data.
- `RD_ADDR`  in  `NUM_RD*ADDR_W`  read addresses; port k uses bits `[k*ADDR_W +: ADDR_W]`.
- `RD_DATA`  out  `NUM_RD*DATA_W`  read data; port k uses bits `[k*DATA_W +: DATA_W]`.
- `RD_BUSY`  out  `NUM_RD`  bit k is 1 when the register addressed by port k has a pending write.
- `ISS`  in  1  issue strobe; marks `ISS_RW` as pending.
- `ISS_RW`  in  `ADDR_W`  destination register of the issuing instruction.
- `FLUSH`  in  1  clears all pending bits; register contents are untouched.
- `PEND_CNT`  out  `ADDR_W+1`  number of registers currently pending.

## Operation
- Storage: `2**ADDR_W` registers of `DATA_W` bits, plus a `2**ADDR_W`-bit pending vector and a `PEND_CNT` counter.
- Reset, while `rst` is high: all registers 0, all pending bits 0, `PEND_CNT` 0. Therefore `RD_DATA` is all 0 and `RD_BUSY` is all 0.
- Write: if `WEN` and `RW != 0`, the register at `RW` takes `busW` on the clock edge.
- Writes to r0 are dropped, and r0 never becomes pending.
- Pending-bit next state, in priority order (highest first):
  - `ISS` with `ISS_RW != 0` sets `pend[ISS_RW]`.
  - `FLUSH` clears all other bits.
  - `WEN` with `RW != 0` clears `pend[RW]`.
  - All other bits hold.
- Issue and writeback to the same register in the same cycle: the bit ends set, because the new producer wins.
- Issue to a register that is already pending: the bit stays set and the count does not change.
- `WEN` to a register that is not pending: data is written and the pending state is unchanged.
- `PEND_CNT` is registered and always equals the popcount of the pending vector. It is updated incrementally as +1, -1 or 0 per cycle, and reloads from the next-state count when `FLUSH` is asserted.
- Read: `RD_DATA` port k is a combinational read of the register at its address; address 0 always returns 0.
- `RD_BUSY` port k is the pending bit of its address (see Configuration); address 0 always gives 0.

## Timing
- Write latency: 1 cycle. Data written at edge N is visible on `RD_DATA` after edge N, without bypass.
- Issue latency: 1 cycle. `RD_BUSY` and `PEND_CNT` reflect an issue after the next edge.
- `RD_DATA` and `RD_BUSY` are purely combinational from `RD_ADDR`, registered state and, with bypass, the writeback inputs. No additional cycle of latency.
- `rst` asserted mid-operation forces reset values immediately, independent of `Clk`. Any in-flight write or issue is lost.

## Configuration
- `REGFILE_BYPASS_EN` defined: write-to-read forwarding is enabled.
  - If `WEN`, `RW != 0` and `RD_ADDR[k] == RW`, `RD_DATA[k]` returns `busW` in the same cycle.
  - `RD_BUSY[k]` is 0 in that cycle unless `ISS` targets the same register in that cycle.
- Macro not defined: reads return stored register contents only.
  - `RD_BUSY` follows the registered pending bit.
  - A same-cycle writeback becomes visible, and busy clears, one cycle later.

## Test plan
- Reset check: assert `rst` with random inputs toggling → all `RD_DATA` 0, `RD_BUSY` 0, `PEND_CNT` 0. Deassert, write 0xDEADBEEF to r5, assert `rst` mid-cycle → r5 reads 0 immediately.
- r0 protection: `WEN=1`, `RW=0`, `busW=0xFFFFFFFF`, `ISS=1`, `ISS_RW=0` → r0 reads 0, `RD_BUSY` 0, `PEND_CNT` stays 0.
- Scoreboard: issue r3, then r7, then r3 again, then `WEN` to r3 with 0x12345678 → `PEND_CNT` goes 1, 2, 2, 1. r3 reads 0x12345678 and is not busy; r7 stays busy.
- Collision: r9 pending; same cycle `WEN` `RW=9` and `ISS` `ISS_RW=9` → r9 still busy, `PEND_CNT` unchanged. Same cycle `FLUSH=1` and `ISS` `ISS_RW=4` with r1, r2 and r9 pending → only r4 is pending, `PEND_CNT=1`.
- Bypass (`REGFILE_BYPASS_EN` defined): `WEN` r12 with 0xCAFE0001 while port 1 reads r12 → `RD_DATA[1]` is 0xCAFE0001 in the same cycle and not busy. Without the macro: old value and busy in that cycle, new value and not busy the next cycle.
- Parametrisation: `DATA_W=64`, `ADDR_W=4`, `NUM_RD=3`. Fill all 15 registers, read three distinct addresses per cycle → all values match. Issue all 15 registers → `PEND_CNT=15`.
